shiftreg_delay_line: RTL and testbench

//  Parametrised successor to the flop-chain shift register. Circular-buffer delay

---
 rtl/shiftreg_delay_line.sv | 81 ++++++++
 tb/tb_shiftreg_delay_line.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_delay_line.sv
// Circular-buffer delay line with a runtime-programmable delay of 1..DEPTH accepted samples.
// Delay mode takes in_data; recirculate mode replays the last delay_eff samples.
module shiftreg_delay_line #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             mode,
  input  logic [AW-1:0]    delay,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    fill_count,
  output logic             primed
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    raddr;
  logic [AW-1:0]    delay_eff;
  logic [XW-1:0]    wptr_x;
  logic [XW-1:0]    delay_x;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] wr_data;
  logic             step;

  always_comb begin
    delay_eff = delay;
    if (delay == '0)
      delay_eff = AW'(1);
    else if (delay > AW'(DEPTH))
      delay_eff = AW'(DEPTH);
  end

  // Widen before subtracting so the wrap branch cannot underflow; both results fit in PW bits.
  always_comb begin
    wptr_x  = XW'(wptr);
    delay_x = XW'(delay_eff);
    if (wptr_x >= delay_x)
      raddr = PW'(wptr_x - delay_x);
    else
      raddr = PW'(wptr_x + XW'(DEPTH) - delay_x);
  end

  assign rd_data  = mem[raddr];
  assign primed   = (fill_count >= delay_eff);
  assign in_ready = ~mode;
  assign step     = mode ? primed : (in_valid & in_ready);
  assign wr_data  = mode ? rd_data : in_data;

  // Storage has no reset; a step coinciding with reset/clear is discarded.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && step)
      mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wptr       <= '0;
      fill_count <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (step) begin
      out_data   <= rd_data;
      out_valid  <= primed;
      wptr       <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
      fill_count <= (fill_count == AW'(DEPTH)) ? fill_count : fill_count + AW'(1);
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shiftreg_delay_line.sv
// Directed self-checking bench for shiftreg_delay_line with WIDTH=8, DEPTH=4.
// Expected values are hand-derived from the circular-buffer behaviour.
module tb_shiftreg_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             mode;
  logic [AW-1:0]    delay;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    fill_count;
  logic             primed;

  int checks = 0;
  int errors = 0;

  shiftreg_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .mode      (mode),
    .delay     (delay),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .fill_count(fill_count),
    .primed    (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_data  = d;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkSample(input string tag, input logic ev, input logic [WIDTH-1:0] ed);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'(ev));
    if (ev)
      checkOutput({tag, ".data"}, 32'(out_data), 32'(ed));
  endtask

  task automatic doClear();
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    mode     = 1'b0;
    delay    = AW'(3);
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    checkOutput("reset.out_valid", 32'(out_valid), 0);
    checkOutput("reset.out_data", 32'(out_data), 0);
    checkOutput("reset.fill_count", 32'(fill_count), 0);
    checkOutput("reset.in_ready", 32'(in_ready), 1);
    checkOutput("reset.primed", 32'(primed), 0);
    rst_n = 1'b1;

    // Delay 3, back-to-back 1..5
    $display("[TB] delay=3 back-to-back");
    applyStimulus(1'b1, 8'd1); checkSample("t1.s1", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd2); checkSample("t1.s2", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd3); checkSample("t1.s3", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd4); checkSample("t1.s4", 1'b1, 8'd1);
    applyStimulus(1'b1, 8'd5); checkSample("t1.s5", 1'b1, 8'd2);
    applyStimulus(1'b0, 8'd0);
    checkOutput("t1.idle.valid", 32'(out_valid), 0);
    checkOutput("t1.idle.hold", 32'(out_data), 2);
    checkOutput("t1.fill_sat", 32'(fill_count), 4);

    // Clamping: delay 0 acts as 1, delay 7 (largest code above DEPTH) acts as DEPTH
    $display("[TB] delay clamping");
    doClear();
    checkOutput("clr.fill_count", 32'(fill_count), 0);
    checkOutput("clr.out_data", 32'(out_data), 0);
    checkOutput("clr.out_valid", 32'(out_valid), 0);
    delay = AW'(0);
    applyStimulus(1'b1, 8'd11); checkSample("t2a.s1", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd12); checkSample("t2a.s2", 1'b1, 8'd11);
    applyStimulus(1'b1, 8'd13); checkSample("t2a.s3", 1'b1, 8'd12);
    doClear();
    delay = AW'(7);
    applyStimulus(1'b1, 8'd21); checkSample("t2b.s1", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd22); checkSample("t2b.s2", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd23); checkSample("t2b.s3", 1'b0, 8'd0);
    checkOutput("t2b.primed3", 32'(primed), 0);
    applyStimulus(1'b1, 8'd24); checkSample("t2b.s4", 1'b0, 8'd0);
    checkOutput("t2b.primed4", 32'(primed), 1);
    applyStimulus(1'b1, 8'd25); checkSample("t2b.s5", 1'b1, 8'd21);

    // Gapped input: idle cycles do not age data
    $display("[TB] gapped input, delay=2");
    doClear();
    delay = AW'(2);
    applyStimulus(1'b1, 8'd31); checkSample("t3.a1", 1'b0, 8'd0);
    applyStimulus(1'b0, 8'd90); checkSample("t3.i1", 1'b0, 8'd0);
    applyStimulus(1'b0, 8'd91); checkSample("t3.i2", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd32); checkSample("t3.a2", 1'b0, 8'd0);
    applyStimulus(1'b0, 8'd92); checkSample("t3.i3", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd33); checkSample("t3.a3", 1'b1, 8'd31);
    applyStimulus(1'b0, 8'd93);
    checkOutput("t3.idle.valid", 32'(out_valid), 0);
    checkOutput("t3.idle.hold", 32'(out_data), 31);

    // Recirculate the last three samples
    $display("[TB] recirculate");
    doClear();
    delay = AW'(3);
    applyStimulus(1'b1, 8'd10);
    applyStimulus(1'b1, 8'd20);
    applyStimulus(1'b1, 8'd30);
    mode = 1'b1;
    #1;
    checkOutput("t4.in_ready", 32'(in_ready), 0);
    applyStimulus(1'b1, 8'd99); checkSample("t4.r1", 1'b1, 8'd10);
    applyStimulus(1'b1, 8'd99); checkSample("t4.r2", 1'b1, 8'd20);
    applyStimulus(1'b1, 8'd99); checkSample("t4.r3", 1'b1, 8'd30);
    applyStimulus(1'b1, 8'd99); checkSample("t4.r4", 1'b1, 8'd10);
    applyStimulus(1'b1, 8'd99); checkSample("t4.r5", 1'b1, 8'd20);
    applyStimulus(1'b1, 8'd99); checkSample("t4.r6", 1'b1, 8'd30);
    checkOutput("t4.fill_sat", 32'(fill_count), 4);
    mode = 1'b0;
    in_valid = 1'b0;

    // Raise the delay from 2 to 4 once fill_count reaches 2
    $display("[TB] delay increase on the fly");
    doClear();
    delay = AW'(2);
    applyStimulus(1'b1, 8'd41);
    applyStimulus(1'b1, 8'd42);
    checkOutput("t5.primed_d2", 32'(primed), 1);
    delay = AW'(4);
    #1;
    checkOutput("t5.primed_d4", 32'(primed), 0);
    applyStimulus(1'b1, 8'd43); checkSample("t5.s3", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd44); checkSample("t5.s4", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd45); checkSample("t5.s5", 1'b1, 8'd41);

    // clear and rst_n arriving alongside a valid input
    $display("[TB] clear and reset mid-stream");
    doClear();
    delay = AW'(1);
    applyStimulus(1'b1, 8'd51);
    applyStimulus(1'b1, 8'd52); checkSample("t6.s2", 1'b1, 8'd51);
    clear = 1'b1;
    applyStimulus(1'b1, 8'd53);
    clear = 1'b0;
    checkOutput("t6.clr.fill", 32'(fill_count), 0);
    checkOutput("t6.clr.valid", 32'(out_valid), 0);
    checkOutput("t6.clr.data", 32'(out_data), 0);
    applyStimulus(1'b1, 8'd61); checkSample("t6.p1", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd62); checkSample("t6.p2", 1'b1, 8'd61);
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'd63);
    rst_n = 1'b1;
    checkOutput("t6.rst.fill", 32'(fill_count), 0);
    checkOutput("t6.rst.valid", 32'(out_valid), 0);
    checkOutput("t6.rst.data", 32'(out_data), 0);
    applyStimulus(1'b1, 8'd71); checkSample("t6.q1", 1'b0, 8'd0);
    applyStimulus(1'b1, 8'd72); checkSample("t6.q2", 1'b1, 8'd71);
    checkOutput("t6.q.fill", 32'(fill_count), 2);
    in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
